// File: rtl/cla16_pipe.sv
// cla16_pipe: two-stage pipelined 16-bit carry-lookahead adder with
// valid/ready handshakes on both sides.
//   Stage 1 registers bitwise propagate/generate and the carry-in.
//   Stage 2 forms group P/G, second-level carries, per-bit carries and
//   registers sum/cout/ovf and the block propagate/generate flags.
// Only WIDTH = 16 is meaningful: 4 groups of 4 bits, two-level lookahead.
module cla16_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             grp_p,
  output logic             grp_g
);

  localparam int GROUPS = WIDTH / 4;

  // In-group carries c1..c3 from bit propagate/generate and group carry-in.
  // Bit 3 p/g only matter for the group P/G, so they are not passed here.
  function automatic logic [3:0] carry4(input logic [2:0] p,
                                        input logic [2:0] g,
                                        input logic       c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Group generate of a 4-bit slice: a carry leaves the group regardless of c0.
  function automatic logic group_g(input logic [3:0] p,
                                   input logic [3:0] g);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Second-level carries into each group: index 0 is cin, index 4 is c16.
  function automatic logic [4:0] carry_l2(input logic [3:0] gp,
                                          input logic [3:0] gg,
                                          input logic       c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = gg[0] | (gp[0] & c0);
    c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
    c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
         | (gp[2] & gp[1] & gp[0] & c0);
    c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
         | (gp[3] & gp[2] & gp[1] & gg[0])
         | (gp[3] & gp[2] & gp[1] & gp[0] & c0);
    return c;
  endfunction

  // Block generate over the four groups; gp[0] never gates a generate term.
  function automatic logic block_g(input logic [3:1] gp,
                                   input logic [3:0] gg);
    return gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
         | (gp[3] & gp[2] & gp[1] & gg[0]);
  endfunction

  logic             vld_p1;
  logic [WIDTH-1:0] p_p1;
  logic [WIDTH-1:0] g_p1;
  logic             cin_p1;

  logic             s2_en;
  logic             accept;

  logic [GROUPS-1:0] gp;
  logic [GROUPS-1:0] gg;
  logic [GROUPS:0]   gc;
  logic [WIDTH-1:0]  c;
  logic [WIDTH-1:0]  sum_n;
  logic              cout_n;
  logic              ovf_n;
  logic              grp_p_n;
  logic              grp_g_n;

  // Stage 2 advances when empty or draining; stage 1 when it can hand off.
  assign s2_en    = !out_valid | out_ready;
  assign in_ready = !vld_p1 | s2_en;
  assign accept   = in_valid & in_ready;

  // ---- stage 1: register bit propagate/generate and carry-in ----
  // Loads on accept, empties when its contents move on, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      p_p1   <= '0;
      g_p1   <= '0;
      cin_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      p_p1   <= a ^ b;
      g_p1   <= a & b;
      cin_p1 <= cin;
    end else if (s2_en) begin
      vld_p1 <= 1'b0;
    end
  end

  // ---- stage 2 combinational: two-level lookahead on stage-1 p/g ----
  // Group P/G first, then group carry-ins, then per-bit carries and sum.
  always_comb begin
    gp      = '0;
    gg      = '0;
    gc      = '0;
    c       = '0;
    for (int k = 0; k < GROUPS; k++) begin
      gp[k] = &p_p1[4*k +: 4];
      gg[k] = group_g(p_p1[4*k +: 4], g_p1[4*k +: 4]);
    end
    gc = carry_l2(gp, gg, cin_p1);
    for (int k = 0; k < GROUPS; k++) begin
      c[4*k +: 4] = carry4(p_p1[4*k +: 3], g_p1[4*k +: 3], gc[k]);
    end
    sum_n   = p_p1 ^ c;
    cout_n  = gc[GROUPS];
    ovf_n   = gc[GROUPS] ^ c[WIDTH-1];
    grp_p_n = &gp;
    grp_g_n = block_g(gp[3:1], gg);
  end

  // ---- stage 2 registers: result and out_valid, frozen while stalled ----
  // Result registers only reload when a valid stage-1 entry moves in.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      grp_p     <= 1'b0;
      grp_g     <= 1'b0;
    end else if (s2_en) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        sum   <= sum_n;
        cout  <= cout_n;
        ovf   <= ovf_n;
        grp_p <= grp_p_n;
        grp_g <= grp_g_n;
      end
    end
  end

endmodule

// File: tb/tb_cla16_pipe.sv
// Self-checking bench for cla16_pipe: directed scenarios plus a randomized
// sweep against an arithmetic reference model with an in-order queue.
module tb_cla16_pipe;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        gp;
    logic        gg;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        grp_p;
  logic        grp_g;

  res_t obs;
  assign obs = {sum, cout, ovf, grp_p, grp_g};

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  cla16_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .grp_p(grp_p), .grp_g(grp_g)
  );

  // Reference: plain 17-bit addition; block generate is the carry-out with cin=0.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci);
    res_t r;
    logic [16:0] t;
    logic [16:0] u;
    t = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    u = {1'b0, x} + {1'b0, y};
    r.s  = t[15:0];
    r.co = t[16];
    r.ov = (x[15] == y[15]) && (t[15] != x[15]);
    r.gp = ((x ^ y) == 16'hFFFF);
    r.gg = u[16];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair for exactly one edge (assumes in_ready is 1).
  task automatic present(input logic [15:0] x, input logic [15:0] y, input logic ci);
    in_valid = 1'b1; a = x; b = y; cin = ci;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({out_valid, obs} !== 22'd0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", {out_valid, obs});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_ripple();
    out_ready = 1'b1;
    present(16'hFFFF, 16'h0001, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL ripple_latency1: out_valid got %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || obs !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL ripple_result: got v=%b %h want v=1 %h", out_valid, obs,
                        {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
    end
    tick();
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    present(16'h7FFF, 16'h0000, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || obs !== {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL overflow_result: got v=%b %h want v=1 %h", out_valid, obs,
                        {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int rdy_low = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
    #1; if (in_ready !== 1'b1) rdy_low++;
    tick();
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
    #1; if (in_ready !== 1'b1) rdy_low++;
    tick();
    in_valid = 1'b0;
    #1; if (in_ready !== 1'b1) rdy_low++;
    checks++;
    if (out_valid !== 1'b1 || obs.s !== 16'h5556 || obs.co !== 1'b0 || obs.ov !== 1'b0) begin
      fails++; $display("FAIL b2b_first: got v=%b sum=%h co=%b ov=%b want v=1 sum=5556 co=0 ov=0",
                        out_valid, obs.s, obs.co, obs.ov);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || obs.s !== 16'hFFFE || obs.co !== 1'b1 || obs.ov !== 1'b0) begin
      fails++; $display("FAIL b2b_second: got v=%b sum=%h co=%b ov=%b want v=1 sum=fffe co=1 ov=0",
                        out_valid, obs.s, obs.co, obs.ov);
    end
    tick();
    checks++;
    if (rdy_low !== 0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_ready: in_ready low %0d times, out_valid=%b want 0/0",
                        rdy_low, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] xa [3];
    logic [15:0] xb [3];
    logic        xc [3];
    res_t        snap;
    int          n_acc = 0;
    int          unstable = 0;
    logic        acc;
    for (int i = 0; i < 3; i++) begin
      xa[i] = 16'($urandom); xb[i] = 16'($urandom); xc[i] = 1'($urandom);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; a = xa[0]; b = xb[0]; cin = xc[0];
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1; acc = in_ready;
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc < 3) begin a = xa[n_acc]; b = xb[n_acc]; cin = xc[n_acc]; end
      end
    end
    #1;
    checks++;
    if (n_acc !== 2 || in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_accepts: got %0d accepted in_ready=%b want 2 in_ready=0",
                        n_acc, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || obs !== model(xa[0], xb[0], xc[0])) begin
      fails++; $display("FAIL bp_head: got v=%b %h want v=1 %h", out_valid, obs,
                        model(xa[0], xb[0], xc[0]));
    end
    snap = obs;
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick();
      if (obs !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) unstable++;
    end
    checks++;
    if (unstable !== 0) begin
      fails++; $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || obs !== model(xa[i], xb[i], xc[i])) begin
        fails++; $display("FAIL bp_drain%0d: got v=%b %h want v=1 %h", i, out_valid, obs,
                          model(xa[i], xb[i], xc[i]));
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin n_acc++; in_valid = 1'b0; end
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || n_acc !== 3) begin
      fails++; $display("FAIL bp_empty: got v=%b accepted=%0d want v=0 accepted=3",
                        out_valid, n_acc);
    end
  endtask

  task automatic test_reset_mid();
    int ghosts = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    tick();
    a = 16'h3333; b = 16'h4444; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_full: got v=%b in_ready=%b want 1/0", out_valid, in_ready);
    end
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, obs} !== 22'd0) begin
      fails++; $display("FAIL rstmid_clear: got %h want 0", {out_valid, obs});
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      if (out_valid !== 1'b0) ghosts++;
    end
    checks++;
    if (ghosts !== 0) begin
      fails++; $display("FAIL rstmid_ghost: got %0d stale results want 0", ghosts);
    end
    present(16'h0001, 16'h0001, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_latency: out_valid got %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || obs !== model(16'h0001, 16'h0001, 1'b0)) begin
      fails++; $display("FAIL rstmid_new: got v=%b %h want v=1 %h", out_valid, obs,
                        model(16'h0001, 16'h0001, 1'b0));
    end
    tick();
  endtask

  task automatic test_random();
    res_t exp_q[$];
    res_t snap;
    res_t want;
    logic prev_stall = 1'b0;
    logic prev_v = 1'b0;
    int   n_acc = 0;
    int   cyc = 0;
    int   bad = 0;
    int   stall_bad = 0;
    while ((n_acc < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      cyc++;
      in_valid  = (n_acc < 10000) && ($urandom_range(0, 9) < 8);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall && (out_valid !== prev_v || obs !== snap)) begin
        stall_bad++;
        if (stall_bad <= 5) $display("FAIL rand_stall_hold: got v=%b %h want v=%b %h",
                                     out_valid, obs, prev_v, snap);
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rand_extra: got %h want no result", obs);
        end else begin
          want = exp_q.pop_front();
          if (obs !== want) begin
            fails++; bad++;
            if (bad <= 10) $display("FAIL rand_result: got %h want %h", obs, want);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(model(a, b, cin));
        n_acc++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_v     = out_valid;
      snap       = obs;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (stall_bad !== 0) begin
      fails++; $display("FAIL rand_stall: got %0d unstable stalled cycles want 0", stall_bad);
    end
    checks++;
    if (n_acc !== 10000 || exp_q.size() !== 0) begin
      fails++; $display("FAIL rand_budget: accepted %0d pending %0d want 10000/0",
                        n_acc, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ripple();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cla16_pipe.md
Name: cla16_pipe

Overview:
- Two-stage pipelined 16-bit carry-lookahead adder with valid/ready handshakes on input and output.
- Stage 1 is the propagate/generate generator that feeds the 4-bit lookahead carry units.
- Stage 2 holds four 4-bit lookahead carry units plus one second-level unit, and the sum/flag logic.
- Serves as the registered adder slice for the datapath; accepts one operand pair per cycle when not stalled.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported: 4 groups x 4 bits, two-level lookahead.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair a/b/cin presented
- in_ready  output  1  stage 1 can accept this cycle
- a  input  16  operand A
- b  input  16  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer accepts result this cycle
- sum  output  16  a + b + cin, low 16 bits
- cout  output  1  carry out of bit 15
- ovf  output  1  two's-complement overflow, c16 ^ c15
- grp_p  output  1  block propagate, AND of all 16 bit-propagates
- grp_g  output  1  block generate, second-level G of the four groups

Behaviour:
- Reset (rst=1 at a clock edge):
  - s1_valid <= 0 and out_valid <= 0.
  - sum, cout, ovf, grp_p, grp_g <= 0.
  - Internal p/g/cin registers <= 0.
  - rst overrides any handshake in the same cycle.
  - An in-flight transaction is discarded; no result for it ever appears.
- Handshake rules:
  - Accept occurs when in_valid & in_ready.
  - Deliver occurs when out_valid & out_ready.
  - s2_en = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_en. This is combinational from out_ready; there is no in_valid -> in_ready path.
  - The result registers and out_valid must not change while out_valid=1 and out_ready=0.
- Stage 1, on accept:
  - p1 <= a ^ b, g1 <= a & b, cin1 <= cin, s1_valid <= 1.
  - When s1_valid is set, s2_en=1 and there is no new accept, s1_valid <= 0.
  - When s1_valid=1 and s2_en=0, all stage-1 registers hold.
- Stage 2, when s2_en=1:
  - out_valid <= s1_valid.
  - If s1_valid=1, load the result registers from the combinational lookahead on p1/g1/cin1. If s1_valid=0, the result registers may hold.
- Lookahead, per group k = 0..3:
  - Bits 4k..4k+3 produce in-group carries and group Pk/Gk with the standard 4-bit lookahead equations.
  - The second level combines P0..P3/G0..G3 with cin1 to form the group carry-ins c4, c8, c12 and c16.
- Result equations:
  - sum[i] = p1[i] ^ c[i], where c[0] = cin1.
  - cout = c16.
  - ovf = c16 ^ c15.
  - grp_p = P3&P2&P1&P0.
  - grp_g = second-level G. It is independent of cin.
- Latency and throughput:
  - Latency is 2 cycles: an accept at edge N gives out_valid=1 after edge N+1.
  - Full throughput of 1 transaction/cycle when out_ready is held at 1.
- Boundary conditions:
  - Both stages full with out_ready=0: in_ready=0, everything holds, and no data is lost or duplicated.
  - Simultaneous accept and deliver: both take effect on the same edge. Stage 1 is overwritten with the new pair only after its old contents move to stage 2.
  - Arithmetic wraps modulo 2^16; cout carries the 17th bit.
  - Bit 15 has no sign extension; ovf is computed from carries only.
- Ordering: results leave in the order accepted; there is no reordering or bypass.

Test Plan:
- Carry ripple through all groups: after reset, a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> two cycles later out_valid=1, sum=0x0000, cout=1, ovf=0, grp_p=0, grp_g=1.
- Signed overflow with carry-in: a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1, grp_p=0, grp_g=0.
- Back-to-back throughput: a=0x1234, b=0x4321, cin=1, then a=0xFFFF, b=0xFFFF, cin=0 on consecutive cycles -> sum=0x5556, cout=0, ovf=0; next cycle sum=0xFFFE, cout=1, ovf=0.
  - in_ready must stay 1 throughout.
- Backpressure: hold out_ready=0 and offer 3 transactions.
  - Exactly 2 are accepted, then in_ready=0.
  - Outputs stay stable for 5 cycles.
  - After out_ready=1, results appear in order, one per cycle, with none lost or duplicated.
- Reset mid-operation: pulse rst=1 for one cycle while both stages are valid -> the next cycle shows out_valid=0 and all outputs 0.
  - The dropped transactions never appear.
  - A new a=0x0001, b=0x0001 gives sum=0x0002 with the normal 2-cycle latency.
- Randomized sweep: 10k random a/b/cin with random out_ready -> every delivered result matches a reference model (sum/cout/ovf/grp_p/grp_g) in accept order.
